bist_ctrl: RTL

- Sequencer inside the BIST wrapper. On request, it drives pseudo-random patterns into the circuit under test (CUT, the b01 FSM: 2 PIs, 2 POs).
- It compacts the CUT responses in a MISR and compares the final signature against a golden value.
- It produces the bist_end and pass_nfail signals consumed at the wrapper boundary and by the system-level bench.

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_lfsr16.sv | 22 ++
 rtl/bist_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared constants for the BIST sequencer: state encodings, LFSR taps, default seed.
package bist_pkg;

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 16;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] INIT  = 3'd1;
    localparam logic [STATE_W-1:0] RUN   = 3'd2;
    localparam logic [STATE_W-1:0] FLUSH = 3'd3;
    localparam logic [STATE_W-1:0] DONE  = 3'd4;

    // Taps for x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10)
    localparam logic [LFSR_W-1:0] TAP_MASK     = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // One Fibonacci step: shift left, feedback into bit 0, then fold in data
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                    input logic [LFSR_W-1:0] d);
        return {q[LFSR_W-2:0], ^(q & TAP_MASK)} ^ d;
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci shift register; data_in = 0 is a pattern generator, data_in = response is a MISR.
module bist_lfsr16
    import bist_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] data_in,
    output logic [LFSR_W-1:0] q
);

    // Load has priority over stepping
    always_ff @(posedge clk) begin
        if (load) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr_next(q, data_in);
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer: applies LFSR patterns to the CUT, compacts responses in a MISR, checks the signature.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned       N_PAT      = 200,
    parameter int unsigned       PI_W       = 2,
    parameter int unsigned       PO_W       = 2,
    parameter int unsigned       SIG_W      = 16,
    parameter logic [SIG_W-1:0]  LFSR_SEED  = DEFAULT_SEED,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bist_start,
    input  logic [PO_W-1:0] cut_po,
    output logic [PI_W-1:0] cut_pi,
    output logic            cut_reset,
    output logic            test_mode,
    output logic            bist_end,
    output logic            pass_nfail
);

    // An all-zero seed would lock the LFSR, so substitute 1
    localparam logic [SIG_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? SIG_W'(1) : LFSR_SEED;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAT - 1);

    logic [STATE_W-1:0] state, next_state;
    logic [CNT_W-1:0]   pat_cnt;
    logic [SIG_W-1:0]   lfsr_q, misr_q;
    logic               lfsr_load, lfsr_en, misr_load, misr_en;

    logic [PI_W-1:0]    cut_pi_d;
    logic               cut_reset_d, test_mode_d, bist_end_d, pass_nfail_d;

    bist_lfsr16 u_lfsr (
        .clk     (clk),
        .load    (lfsr_load),
        .en      (lfsr_en),
        .seed    (SEED_EFF),
        .data_in ('0),
        .q       (lfsr_q)
    );

    bist_lfsr16 u_misr (
        .clk     (clk),
        .load    (misr_load),
        .en      (misr_en),
        .seed    ('0),
        .data_in (SIG_W'(cut_po)),
        .q       (misr_q)
    );

    // Register load/step controls; reset reuses the load path
    always_comb begin
        lfsr_load = reset || (state == INIT);
        misr_load = reset || (state == INIT);
        lfsr_en   = (state == RUN);
        misr_en   = (state == RUN) || (state == FLUSH);
    end

    // Next state and next registered output values
    always_comb begin
        next_state   = state;
        cut_pi_d     = '0;
        cut_reset_d  = 1'b0;
        test_mode_d  = 1'b0;
        bist_end_d   = (state == DONE);
        pass_nfail_d = pass_nfail;

        case (state)
            IDLE:    if (bist_start) next_state = INIT;
            INIT:    next_state = RUN;
            RUN:     if (pat_cnt == CNT_LAST) next_state = FLUSH;
            FLUSH:   next_state = DONE;
            DONE:    if (!bist_start) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Final MISR value is settled once in DONE, so compare there
        if (state == DONE) begin
            pass_nfail_d = (misr_q == GOLDEN_SIG);
        end

        // Outputs follow the state being entered so they line up with it
        case (next_state)
            INIT: begin
                cut_reset_d  = 1'b1;
                test_mode_d  = 1'b1;
                pass_nfail_d = 1'b0;
            end
            RUN: begin
                test_mode_d = 1'b1;
                cut_pi_d    = (state == INIT) ? SEED_EFF[PI_W-1:0]
                                              : PI_W'(lfsr_next(lfsr_q, '0));
            end
            FLUSH: begin
                test_mode_d = 1'b1;
                cut_pi_d    = cut_pi;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cut_pi     <= '0;
            cut_reset  <= 1'b0;
            test_mode  <= 1'b0;
            bist_end   <= 1'b0;
            pass_nfail <= 1'b0;
        end else begin
            state      <= next_state;
            cut_pi     <= cut_pi_d;
            cut_reset  <= cut_reset_d;
            test_mode  <= test_mode_d;
            bist_end   <= bist_end_d;
            pass_nfail <= pass_nfail_d;
        end
    end

    // Pattern counter: cleared in INIT, counts RUN cycles
    always_ff @(posedge clk) begin
        if (reset || (state == INIT)) begin
            pat_cnt <= '0;
        end else if (state == RUN) begin
            pat_cnt <= pat_cnt + CNT_W'(1);
        end
    end

endmodule
